// File: rtl/redux_mem_loader.sv
// redux_mem_loader: boot-time loader for the redux core memory.
// Takes a valid/ready byte stream and writes it to consecutive addresses
// starting at a captured base, holding the core in halt until the image
// is complete, then pulsing done.
module redux_mem_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_halt,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W + 1)'(1);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   remaining;
    logic              length_ok;
    logic              start_ok;
    logic              start_bad;
    logic              beat;
    logic              last_beat;

    // Qualify the start request and the stream handshake.
    always_comb begin
        length_ok = (length != '0) && (length <= DEPTH_L);
        start_ok  = (state == IDLE) && start && length_ok;
        start_bad = (state == IDLE) && start && !length_ok;
        in_ready  = (state == LOAD);
        busy      = (state == LOAD);
        beat      = in_ready && in_valid;
        last_beat = beat && (remaining == ONE_L);
    end

    // Next-state logic: IDLE -> LOAD -> FIN -> IDLE.
    always_comb begin
        // NOTE: assign a default first so every path drives state_nx and no latch is inferred.
        state_nx = state;
        unique case (state)
            IDLE:    if (start_ok) state_nx = LOAD;
            LOAD:    if (last_beat) state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_nx;
        end
    end

    // Pointer, counter, write port and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: reset clears every control and datapath register here; the memory itself lives outside and keeps its contents.
            ptr       <= '0;
            remaining <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            cpu_halt  <= 1'b0;
        end else begin
            mem_we <= beat;
            done   <= (state == FIN);

            if (beat) begin
                mem_addr  <= ptr;
                mem_wdata <= in_data;
                ptr       <= ptr + 1'b1;
                remaining <= remaining - ONE_L;
            end

            if (start_ok) begin
                ptr       <= base_addr;
                remaining <= length;
                err       <= 1'b0;
            end else if (start_bad) begin
                err <= 1'b1;
            end

            // Halt from the cycle after accept until the cycle after done.
            if (start_ok) begin
                cpu_halt <= 1'b1;
            end else if (done) begin
                cpu_halt <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_redux_mem_loader.sv
// tb_redux_mem_loader: scoreboard bench for redux_mem_loader.
// The driver pushes the expected (address, data) of every accepted beat;
// a negedge monitor pops and compares each mem_we and tracks done/halt.
module tb_redux_mem_loader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] base_addr;
    logic [8:0] length;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_halt;
    logic       busy;
    logic       done;
    logic       err;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] memoria [256];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         last_we_cyc = -10;
    int         done_count = 0;
    int         halt_cycles = 0;

    redux_mem_loader #(.ADDR_W(8), .DATA_W(8), .DEPTH(256)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_halt  (cpu_halt),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare each write against the scoreboard, model memory, watch done.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (cpu_halt) halt_cycles++;
        if (mem_we) begin
            check("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e.addr));
                check("wr_data", 32'(mem_wdata), 32'(e.data));
            end
            memoria[mem_addr] = mem_wdata;
            last_we_cyc = cyc;
        end
        if (done) begin
            done_count++;
            check("done_after_last_write", 32'(cyc - last_we_cyc), 32'd1);
        end
    end

    task automatic pulse_start(input logic [7:0] b, input logic [8:0] len);
        base_addr = b;
        length    = len;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Offer one word; push its expected write once the handshake is seen.
    task automatic do_beat(input logic [7:0] d, input logic [7:0] a);
        logic got;
        got      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back('{a, d});
                @(posedge clk);
                #1;
                got = 1'b1;
                break;
            end
        end
        check("beat_accepted", 32'(got), 32'd1);
    endtask

    task automatic bubble();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int target);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (done_count >= target) break;
        end
        check("done_seen", 32'(done_count >= target), 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int dc;
        for (int j = 0; j < 256; j++) memoria[j] = 8'hEE;
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        in_data   = '0;
        in_valid  = 1'b0;
        #23;
        // Reset state
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_halt", 32'(cpu_halt), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        rst_n = 1'b1;
        idle_cycles(2);

        // 1: basic load, in_valid held high
        halt_cycles = 0;
        pulse_start(8'd0, 9'd4);
        check("t1_busy", 32'(busy), 32'd1);
        do_beat(8'd10, 8'd0);
        do_beat(8'd20, 8'd1);
        do_beat(8'd30, 8'd2);
        do_beat(8'd40, 8'd3);
        in_valid = 1'b0;
        wait_done(1);
        idle_cycles(4);
        check("t1_done_once", 32'(done_count), 32'd1);
        check("t1_halt_cycles", 32'(halt_cycles), 32'd6);
        check("t1_mem0", 32'(memoria[0]), 32'd10);
        check("t1_mem1", 32'(memoria[1]), 32'd20);
        check("t1_mem2", 32'(memoria[2]), 32'd30);
        check("t1_mem3", 32'(memoria[3]), 32'd40);

        // 2: bubbles 1,0,0,1,0,1
        pulse_start(8'h10, 9'd3);
        do_beat(8'hA1, 8'h10);
        bubble();
        bubble();
        do_beat(8'hA2, 8'h11);
        bubble();
        do_beat(8'hA3, 8'h12);
        in_valid = 1'b0;
        wait_done(2);
        idle_cycles(3);
        check("t2_done_once", 32'(done_count), 32'd2);

        // 3: wrap-around
        pulse_start(8'd254, 9'd4);
        do_beat(8'd1, 8'd254);
        do_beat(8'd2, 8'd255);
        do_beat(8'd3, 8'd0);
        do_beat(8'd4, 8'd1);
        in_valid = 1'b0;
        wait_done(3);
        idle_cycles(3);
        check("t3_err", 32'(err), 32'd0);
        check("t3_mem255", 32'(memoria[255]), 32'd2);
        check("t3_mem1", 32'(memoria[1]), 32'd4);

        // 4: illegal lengths, word offered in IDLE is not taken
        in_valid = 1'b1;
        in_data  = 8'h55;
        pulse_start(8'd0, 9'd0);
        @(negedge clk);
        check("t4_err_len0", 32'(err), 32'd1);
        check("t4_busy_len0", 32'(busy), 32'd0);
        check("t4_halt_len0", 32'(cpu_halt), 32'd0);
        check("t4_ready_len0", 32'(in_ready), 32'd0);
        pulse_start(8'd0, 9'd257);
        @(negedge clk);
        check("t4_err_len257", 32'(err), 32'd1);
        check("t4_busy_len257", 32'(busy), 32'd0);
        check("t4_halt_len257", 32'(cpu_halt), 32'd0);
        in_valid = 1'b0;
        idle_cycles(2);
        pulse_start(8'h20, 9'd1);
        check("t4_err_cleared", 32'(err), 32'd0);
        do_beat(8'h77, 8'h20);
        in_valid = 1'b0;
        wait_done(4);
        idle_cycles(3);

        // 5: full image, stray start mid-load
        pulse_start(8'd0, 9'd256);
        for (int i = 0; i < 256; i++) begin
            if (i == 100) begin
                base_addr = 8'h80;
                length    = 9'd0;
                start     = 1'b1;
            end
            do_beat(8'(i), 8'(i));
            start = 1'b0;
        end
        in_valid = 1'b0;
        wait_done(5);
        idle_cycles(3);
        check("t5_done_once", 32'(done_count), 32'd5);
        check("t5_err_untouched", 32'(err), 32'd0);
        for (int j = 0; j < 256; j++) check("t5_mem", 32'(memoria[j]), 32'(j));

        // 6: mid-load reset after the third write
        dc = done_count;
        pulse_start(8'h40, 9'd8);
        do_beat(8'hC0, 8'h40);
        do_beat(8'hC1, 8'h41);
        do_beat(8'hC2, 8'h42);
        in_valid = 1'b0;
        @(negedge clk);
        check("t6_third_write", 32'(mem_we), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_we_drop", 32'(mem_we), 32'd0);
        check("t6_busy_drop", 32'(busy), 32'd0);
        check("t6_halt_drop", 32'(cpu_halt), 32'd0);
        idle_cycles(2);
        #2;
        rst_n = 1'b1;
        idle_cycles(6);
        check("t6_no_done", 32'(done_count), 32'(dc));
        check("t6_mem40", 32'(memoria[8'h40]), 32'hC0);
        check("t6_mem41", 32'(memoria[8'h41]), 32'hC1);
        check("t6_mem42", 32'(memoria[8'h42]), 32'hC2);
        pulse_start(8'h90, 9'd2);
        do_beat(8'hAA, 8'h90);
        do_beat(8'hBB, 8'h91);
        in_valid = 1'b0;
        wait_done(dc + 1);
        idle_cycles(3);
        check("t6_fresh_mem90", 32'(memoria[8'h90]), 32'hAA);
        check("t6_fresh_mem91", 32'(memoria[8'h91]), 32'hBB);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
